// File: rtl/cpu_branch_pkg.sv
// Shared branch-unit definitions: default opcode table,
// FSM state encoding and shadow counter width.
package cpu_branch_pkg;

  localparam logic [3:0] DEF_JMP = 4'b1111;
  localparam logic [3:0] DEF_JNC = 4'b1110;
  localparam logic [3:0] DEF_JC  = 4'b1100;
  localparam logic [3:0] DEF_JNZ = 4'b1101;

  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch opcode table: flags a branch opcode and
// evaluates its carry/zero condition.
module branch_cond
  import cpu_branch_pkg::*;
#(
  parameter int OP_WIDTH = 4,
  parameter logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(DEF_JMP),
  parameter logic [OP_WIDTH-1:0] OP_JNC = OP_WIDTH'(DEF_JNC),
  parameter logic [OP_WIDTH-1:0] OP_JC  = OP_WIDTH'(DEF_JC),
  parameter logic [OP_WIDTH-1:0] OP_JNZ = OP_WIDTH'(DEF_JNZ)
) (
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                cflag,
  input  logic                zflag,
  output logic                is_branch,
  output logic                cond_true
);

  // Match the opcode against the table and pick its condition.
  always_comb begin
    is_branch = 1'b1;
    cond_true = 1'b0;
    unique case (1'b1)
      (opcode == OP_JMP): cond_true = 1'b1;
      (opcode == OP_JNC): cond_true = ~cflag;
      (opcode == OP_JC):  cond_true = cflag;
      (opcode == OP_JNZ): cond_true = ~zflag;
      default:            is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner: decodes branches, holds the
// fetch stage busy for a fixed shadow after each one.
module pc_branch_unit
  import cpu_branch_pkg::*;
#(
  parameter int PC_WIDTH      = 4,
  parameter int OP_WIDTH      = 4,
  parameter int SHADOW_CYCLES = 1,
  parameter logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(DEF_JMP),
  parameter logic [OP_WIDTH-1:0] OP_JNC = OP_WIDTH'(DEF_JNC),
  parameter logic [OP_WIDTH-1:0] OP_JC  = OP_WIDTH'(DEF_JC),
  parameter logic [OP_WIDTH-1:0] OP_JNZ = OP_WIDTH'(DEF_JNZ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                cflag,
  input  logic                zflag,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] pc,
  output logic                load,
  output logic                busy,
  output logic                taken
);

  if (SHADOW_CYCLES < 1 || SHADOW_CYCLES > 7) begin : g_bad_shadow
    $error("pc_branch_unit: SHADOW_CYCLES must be 1..7");
  end

  if (OP_JMP == OP_JNC || OP_JMP == OP_JC ||
      OP_JMP == OP_JNZ || OP_JNC == OP_JC ||
      OP_JNC == OP_JNZ || OP_JC == OP_JNZ) begin : g_dup_op
    $error("pc_branch_unit: branch opcodes must differ");
  end

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SHADOW_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PC_WIDTH-1:0] target_q;
  logic                taken_q;
  logic                is_branch;
  logic                cond_true;

  branch_cond #(
    .OP_WIDTH (OP_WIDTH),
    .OP_JMP   (OP_JMP),
    .OP_JNC   (OP_JNC),
    .OP_JC    (OP_JC),
    .OP_JNZ   (OP_JNZ)
  ) u_cond (
    .opcode    (opcode),
    .cflag     (cflag),
    .zflag     (zflag),
    .is_branch (is_branch),
    .cond_true (cond_true)
  );

  // taken_q is only ever set for the first shadow cycle,
  // so it doubles as the load pulse.
  assign busy  = (state == SHADOW);
  assign load  = taken_q;
  assign taken = taken_q;

  // PC, shadow FSM and counter; everything freezes on stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      state    <= IDLE;
      cnt      <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
    end else if (!stall) begin
      pc <= taken_q ? target_q : pc + PC_WIDTH'(1);
      unique case (state)
        IDLE: begin
          if (is_branch) begin
            state    <= SHADOW;
            cnt      <= CNT_INIT;
            target_q <= target;
            taken_q  <= cond_true;
          end
        end
        SHADOW: begin
          taken_q <= 1'b0;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomised and directed bench for pc_branch_unit,
// one instance with a 1-cycle and one with a 3-cycle shadow.
module tb_pc_branch_unit;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] JMP = 4'hF;
  localparam logic [3:0] JNC = 4'hE;
  localparam logic [3:0] JC  = 4'hC;
  localparam logic [3:0] JNZ = 4'hD;

  logic       clock;
  logic       reset;
  logic [3:0] opcode;
  logic [3:0] target;
  logic       cflag;
  logic       zflag;
  logic       stall;

  logic [3:0] pc1, pc3;
  logic       load1, load3;
  logic       busy1, busy3;
  logic       taken1, taken3;

  int total = 0;
  int bad   = 0;

  int         m_pc[2];
  int         m_left[2];
  bit         m_pend[2];
  logic [3:0] m_tgt[2];
  int         m_sc[2] = '{1, 3};

  pc_branch_unit #(.SHADOW_CYCLES(1)) u_dut1 (
    .clock (clock), .reset (reset),
    .opcode(opcode), .target(target),
    .cflag (cflag), .zflag (zflag),
    .stall (stall), .pc    (pc1),
    .load  (load1), .busy  (busy1),
    .taken (taken1)
  );

  pc_branch_unit #(.SHADOW_CYCLES(3)) u_dut3 (
    .clock (clock), .reset (reset),
    .opcode(opcode), .target(target),
    .cflag (cflag), .zflag (zflag),
    .stall (stall), .pc    (pc3),
    .load  (load3), .busy  (busy3),
    .taken (taken3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_br(input logic [3:0] op);
    return op inside {JMP, JNC, JC, JNZ};
  endfunction

  function automatic bit cond_of(input logic [3:0] op,
                                 input logic c,
                                 input logic z);
    case (op)
      JMP:     return 1'b1;
      JNC:     return !c;
      JC:      return c;
      JNZ:     return !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]   = 0;
      m_left[i] = 0;
      m_pend[i] = 1'b0;
      m_tgt[i]  = '0;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (stall) return;
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] > 0) begin
        m_pc[i]   = m_pend[i] ? int'(m_tgt[i])
                              : (m_pc[i] + 1) % 16;
        m_pend[i] = 1'b0;
        m_left[i] = m_left[i] - 1;
      end else begin
        if (is_br(opcode)) begin
          m_pend[i] = cond_of(opcode, cflag, zflag);
          m_tgt[i]  = target;
          m_left[i] = m_sc[i];
        end
        m_pc[i] = (m_pc[i] + 1) % 16;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc1",    32'(pc1),    32'(m_pc[0]));
    chk("load1",  32'(load1),  32'(m_pend[0]));
    chk("busy1",  32'(busy1),  32'(m_left[0] > 0));
    chk("taken1", 32'(taken1), 32'(m_pend[0]));
    chk("pc3",    32'(pc3),    32'(m_pc[1]));
    chk("load3",  32'(load3),  32'(m_pend[1]));
    chk("busy3",  32'(busy3),  32'(m_left[1] > 0));
    chk("taken3", 32'(taken3), 32'(m_pend[1]));
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic step(input logic [3:0] op,
                      input logic [3:0] tg,
                      input logic c,
                      input logic z,
                      input logic st);
    opcode = op;
    target = tg;
    cflag  = c;
    zflag  = z;
    stall  = st;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) step(NOP, 4'h0, 0, 0, 0);
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_pc",   32'(pc1),   32'h0);
    chk("rst_load", 32'(load1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_busy3",32'(busy3), 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int  busy_cnt;
    bit  saw1;
    reset  = 1'b1;
    opcode = NOP;
    target = '0;
    cflag  = 1'b0;
    zflag  = 1'b0;
    stall  = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    for (int k = 1; k <= 20; k++) begin
      step(NOP, 4'h0, 0, 0, 0);
      chk("nop_pc", 32'(pc1), 32'(k % 16));
    end

    do_reset();
    nop(3);
    step(JMP, 4'hA, 0, 0, 0);
    chk("jmp_load",  32'(load1),  32'h1);
    chk("jmp_busy",  32'(busy1),  32'h1);
    chk("jmp_taken", 32'(taken1), 32'h1);
    nop(1);
    chk("jmp_pc",    32'(pc1),    32'hA);
    chk("jmp_idle",  32'(busy1),  32'h0);

    do_reset();
    nop(5);
    step(JNC, 4'h7, 1, 0, 0);
    chk("jnc_nt_busy", 32'(busy1), 32'h1);
    chk("jnc_nt_load", 32'(load1), 32'h0);
    chk("jnc_nt_pc6",  32'(pc1),   32'h6);
    nop(1);
    chk("jnc_nt_pc7",  32'(pc1),   32'h7);
    step(JNC, 4'h2, 0, 0, 0);
    chk("jnc_t_load",  32'(load1), 32'h1);
    nop(1);
    chk("jnc_t_pc",    32'(pc1),   32'h2);

    do_reset();
    nop(2);
    step(JNZ, 4'h9, 0, 0, 0);
    busy_cnt = busy3 ? 1 : 0;
    saw1     = 1'b0;
    step(JMP, 4'h1, 0, 0, 0);
    chk("jnz_pc9", 32'(pc3), 32'h9);
    for (int k = 0; k < 5; k++) begin
      busy_cnt += busy3 ? 1 : 0;
      if (pc3 == 4'h1) saw1 = 1'b1;
      if (k < 4) step(NOP, 4'h0, 0, 0, 0);
    end
    chk("shadow3_len", 32'(busy_cnt), 32'd3);
    chk("shadow3_ign", 32'(saw1),     32'd0);

    do_reset();
    nop(2);
    step(JNC, 4'hC, 1, 0, 1);
    chk("stall_pc_a", 32'(pc1), 32'h2);
    step(JNC, 4'hC, 0, 0, 1);
    chk("stall_pc_b", 32'(pc1), 32'h2);
    chk("stall_busy", 32'(busy1), 32'h0);
    step(JNC, 4'hC, 0, 0, 0);
    chk("stall_load", 32'(load1), 32'h1);
    nop(1);
    chk("stall_pc_c", 32'(pc1), 32'hC);
    step(JNC, 4'h5, 0, 0, 1);
    step(JNC, 4'h5, 1, 0, 0);
    chk("stall_nt", 32'(load1), 32'h0);
    nop(2);

    do_reset();
    nop(1);
    step(JMP, 4'hB, 0, 0, 0);
    chk("pre_rst_load", 32'(load1), 32'h1);
    do_reset();
    nop(1);
    chk("post_rst_pc", 32'(pc1), 32'h1);

    for (int k = 0; k < 400; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 1) == 0)
           ? 4'($urandom_range(12, 15))
           : 4'($urandom_range(0, 15));
      step(op, 4'($urandom),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
